m10k_arbiter: RTL and testbench
===============================

Name: m10k_arbiter

Overview:
Round-robin arbiter and sequencer that shares one M10K memory port among NUM_REQ requesters, for example the matrix loader and the compute engine.
It grants at most one access per cycle, registers the winning request onto the memory's read/write/address/writedata pins, and tracks outstanding reads in a latency pipeline.
It then returns readdata to the requester that issued the read, with an rvalid strobe.
It sits between the datapath engines and the M10K wrapper.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
ADDR_W, 8, memory address width.
DATA_W, 32, memory data width.
READ_LATENCY, 1, cycles from mem_read asserted to mem_readdata valid (1..4).

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
req  input  NUM_REQ  per-requester access request; held until granted.
we  input  NUM_REQ  per-requester 1=write, 0=read; valid while req is high.
addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
wdata  input  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
grant  output  NUM_REQ  one-hot; combinational; request accepted in any cycle where req[i] & grant[i].
rvalid  output  NUM_REQ  one-hot read-return strobe, one pulse per accepted read.
rdata  output  DATA_W  read data, valid when any rvalid bit is high.
mem_read  output  1  registered read strobe to M10K.
mem_write  output  1  registered write strobe to M10K.
mem_address  output  ADDR_W  registered address to M10K.
mem_writedata  output  DATA_W  registered write data to M10K.
mem_readdata  input  DATA_W  M10K read data.

Behaviour:
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, rvalid=0, rdata=0.
- Reset state: last-grant pointer = NUM_REQ-1, so requester 0 has first priority. All read-tracking pipeline stages are invalid.
- grant is combinational from req and the pointer and is never asserted for a requester with req=0.
- Arbitration order: search starts at requester (ptr+1) mod NUM_REQ and wraps. The first requester found with req=1 gets grant.
- The pointer updates to the granted index only on a grant. Idle cycles leave it unchanged.
- Each cycle has zero or one grant. grant is all-zero when req is all-zero.
- Issue stage (cycle T+1 after a grant in cycle T):
  - mem_read = ~we[g]; mem_write = we[g].
  - mem_address = addr[g]; mem_writedata = wdata[g].
  - mem_read and mem_write are never both 1.
- With no grant in T: mem_read=mem_write=0 in T+1. mem_address and mem_writedata hold their previous values.
- Read tracking: shift register of depth READ_LATENCY carrying {valid, owner index}.
  - The entry enters when mem_read is driven.
  - At the tail, rvalid[owner] pulses for exactly 1 cycle and rdata is registered from mem_readdata.
  - Total read latency is 2+READ_LATENCY cycles from grant (grant cycle T, mem_read at T+1, rvalid at T+2+READ_LATENCY-1+... = T+1+READ_LATENCY+1 with registered rdata). READ_LATENCY=1 gives rvalid in T+3.
- rdata holds its last value when no rvalid is asserted.
- Pipeline is fully pipelined: one read may be accepted every cycle. Returns arrive in issue order and never collide.
- Writes produce no rvalid. Acceptance (req&grant) is the only write acknowledgement.
- Read-after-write to the same address from any requesters is ordered by grant order. The arbiter adds no forwarding.
- A requester may keep req high across back-to-back cycles.
  - With a single active requester, it is granted every cycle.
  - With all active, each is granted once per NUM_REQ cycles; starvation is impossible.
- Reset mid-operation: all in-flight reads are dropped, and no rvalid is emitted after reset is sampled. mem_read and mem_write are 0 in the cycle after reset.
- Unused high bits of the pointer never select an index >= NUM_REQ.

Test Plan:
- Reset then idle: hold reset 2 cycles with req=0 -> grant=0, mem_read=mem_write=0, mem_address=0, rvalid=0 on every cycle.
- Single write then read: req0 write addr=0x12 wdata=0xDEADBEEF, then read addr=0x12. Model returns stored data.
  - Expect mem_write=1 with address 0x12 one cycle after grant.
  - Expect rvalid[0]=1 with rdata=0xDEADBEEF exactly 3 cycles after the read grant (READ_LATENCY=1), and rvalid[1]=0.
- Round-robin fairness: req0 and req1 both held high reading 0x01 and 0x02 for 8 cycles after reset.
  - Expect grants alternate 0,1,0,1…, starting with requester 0.
  - Expect mem_address alternates 0x01,0x02.
  - Expect rvalid alternates owners in the same order.
- Back-to-back pipelined reads, READ_LATENCY=2: req1 reads 0x10..0x13 on consecutive cycles.
  - Expect four consecutive rvalid[1] pulses starting 4 cycles after the first grant.
  - Expect data in address order; no bubbles.
- Pointer holds across idle: grant req1, idle 3 cycles, then assert req0 and req1 together -> req0 granted first.
- Reset mid-flight: grant a read in cycle T and assert reset in T+1 -> no rvalid in any later cycle, and mem_read=0 in T+2.

Source files
------------

// File: rtl/m10k_arbiter_if.sv
// Requester-side bus of the M10K arbiter.
//   req    : per-requester access request, held until granted
//   we     : per-requester write enable (1=write, 0=read), valid with req
//   addr   : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata  : packed write data, requester i at [i*DATA_W +: DATA_W]
//   grant  : one-hot combinational grant; accepted when req[i] & grant[i]
//   rvalid : one-hot read-return strobe, one pulse per accepted read
//   rdata  : read data, valid while any rvalid bit is high
// master = requester side, slave = arbiter side.
interface m10k_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  modport master (
    output req, we, addr, wdata,
    input  grant, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output grant, rvalid, rdata
  );
endinterface

// File: rtl/m10k_arbiter.sv
// Round-robin arbiter sharing one M10K port among NUM_REQ requesters.
// One access is granted per cycle; the winner is registered onto the
// memory pins, and reads are tracked through a READ_LATENCY-deep pipeline
// so the returned data is routed back to the issuing requester.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   bus            : requester bus (slave side), see m10k_arbiter_if
//   mem_read       : registered read strobe to the M10K
//   mem_write      : registered write strobe to the M10K
//   mem_address    : registered address to the M10K
//   mem_writedata  : registered write data to the M10K
//   mem_readdata   : M10K read data, valid READ_LATENCY cycles after mem_read
module m10k_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  m10k_arbiter_if.slave     bus,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  logic [PTR_W-1:0]   ptr_reg;
  logic [NUM_REQ-1:0] grant_next;
  logic [PTR_W-1:0]   gidx_next;
  logic [PTR_W-1:0]   cand_next;
  logic               any_grant;

  logic               mem_read_reg;
  logic               mem_write_reg;
  logic [ADDR_W-1:0]  mem_address_reg;
  logic [DATA_W-1:0]  mem_writedata_reg;
  logic [PTR_W-1:0]   issue_owner_reg;

  // Read-tracking pipeline; stage READ_LATENCY-1 lines up with mem_readdata.
  logic [READ_LATENCY-1:0] valid_pipe_reg;
  logic [PTR_W-1:0]        owner_pipe_reg [READ_LATENCY];

  logic [NUM_REQ-1:0] rvalid_reg;
  logic [DATA_W-1:0]  rdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Search starts one past the last winner and wraps. The modulo keeps the
  // candidate in range even if the pointer ever held an unused code.
  always_comb begin
    grant_next = '0;
    gidx_next  = '0;
    cand_next  = '0;
    any_grant  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_next = PTR_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!any_grant && bus.req[cand_next]) begin
        any_grant  = 1'b1;
        gidx_next  = cand_next;
      end
    end
    if (any_grant) begin
      grant_next[gidx_next] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg           <= PTR_W'(NUM_REQ - 1);
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
      mem_address_reg   <= '0;
      mem_writedata_reg <= '0;
      issue_owner_reg   <= '0;
      valid_pipe_reg    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        owner_pipe_reg[i] <= '0;
      end
      rvalid_reg        <= '0;
      rdata_reg         <= '0;
    end else begin
      // Issue stage: strobes are recomputed every cycle, address/data hold
      // when nothing is granted.
      mem_read_reg  <= any_grant & ~bus.we[gidx_next];
      mem_write_reg <= any_grant &  bus.we[gidx_next];
      if (any_grant) begin
        ptr_reg           <= gidx_next;
        mem_address_reg   <= addr_arr[gidx_next];
        mem_writedata_reg <= wdata_arr[gidx_next];
        issue_owner_reg   <= gidx_next;
      end

      valid_pipe_reg[0] <= mem_read_reg;
      owner_pipe_reg[0] <= issue_owner_reg;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
        owner_pipe_reg[i] <= owner_pipe_reg[i-1];
      end

      rvalid_reg <= '0;
      if (valid_pipe_reg[READ_LATENCY-1]) begin
        rvalid_reg[owner_pipe_reg[READ_LATENCY-1]] <= 1'b1;
        rdata_reg <= mem_readdata;
      end
    end
  end

  assign bus.grant     = grant_next;
  assign bus.rvalid    = rvalid_reg;
  assign bus.rdata     = rdata_reg;
  assign mem_read      = mem_read_reg;
  assign mem_write     = mem_write_reg;
  assign mem_address   = mem_address_reg;
  assign mem_writedata = mem_writedata_reg;

endmodule

// File: tb/tb_m10k_arbiter.sv
module tb_m10k_arbiter;

  typedef struct {
    logic [1:0]  oh;
    logic [31:0] data;
    int          due;
  } ret_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [15:0] addr = '0;
  logic [63:0] wdata = '0;

  // DUT 1: READ_LATENCY=1, DUT 2: READ_LATENCY=2, same requester stimulus.
  logic        m1_read, m1_write, m2_read, m2_write;
  logic [7:0]  m1_addr, m2_addr;
  logic [31:0] m1_wdata, m2_wdata, m1_rdata, m2_rdata;
  logic [31:0] rd1, rd2a, rd2b;
  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];
  logic [31:0] ref_mem [0:255];

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  ret_t q1[$];
  ret_t q2[$];

  logic        exp_mread = 1'b0, exp_mwrite = 1'b0;
  logic [7:0]  exp_maddr = '0;
  logic [31:0] exp_mwdata = '0;

  m10k_arbiter_if #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32)) bus1 ();
  m10k_arbiter_if #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32)) bus2 ();

  assign bus1.req = req;  assign bus1.we = we;  assign bus1.addr = addr;  assign bus1.wdata = wdata;
  assign bus2.req = req;  assign bus2.we = we;  assign bus2.addr = addr;  assign bus2.wdata = wdata;

  m10k_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32), .READ_LATENCY(1)) dut1 (
    .clock(clk), .reset(reset), .bus(bus1.slave),
    .mem_read(m1_read), .mem_write(m1_write), .mem_address(m1_addr),
    .mem_writedata(m1_wdata), .mem_readdata(m1_rdata)
  );

  m10k_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32), .READ_LATENCY(2)) dut2 (
    .clock(clk), .reset(reset), .bus(bus2.slave),
    .mem_read(m2_read), .mem_write(m2_write), .mem_address(m2_addr),
    .mem_writedata(m2_wdata), .mem_readdata(m2_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {24'hA5C300, a};
  endfunction

  // M10K behavioural models: one and two cycles of read latency.
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 256; i++) mem1[i] <= init_word(8'(i));
    else if (m1_write) mem1[m1_addr] <= m1_wdata;
    rd1 <= mem1[m1_addr];
  end
  assign m1_rdata = rd1;

  always @(posedge clk) begin
    if (reset) for (int j = 0; j < 256; j++) mem2[j] <= init_word(8'(j));
    else if (m2_write) mem2[m2_addr] <= m2_wdata;
    rd2a <= mem2[m2_addr];
    rd2b <= rd2a;
  end
  assign m2_rdata = rd2b;

  // Scoreboard: the front entry must appear exactly on its due cycle,
  // and rvalid must stay low on every other cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        if (bus1.rvalid !== q1[0].oh || bus1.rdata !== q1[0].data) begin
          n_err++;
          $display("FAIL ret_lat1 cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                   cyc, bus1.rvalid, bus1.rdata, q1[0].oh, q1[0].data);
        end
        void'(q1.pop_front());
      end else if (bus1.rvalid !== 2'b00) begin
        n_err++;
        $display("FAIL idle_rvalid_lat1 cyc=%0d got rvalid=%b want 00", cyc, bus1.rvalid);
      end
      n_vec++;
      if (q2.size() > 0 && q2[0].due == cyc) begin
        if (bus2.rvalid !== q2[0].oh || bus2.rdata !== q2[0].data) begin
          n_err++;
          $display("FAIL ret_lat2 cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                   cyc, bus2.rvalid, bus2.rdata, q2[0].oh, q2[0].data);
        end
        void'(q2.pop_front());
      end else if (bus2.rvalid !== 2'b00) begin
        n_err++;
        $display("FAIL idle_rvalid_lat2 cyc=%0d got rvalid=%b want 00", cyc, bus2.rvalid);
      end
    end
  end

  // One cycle: check issue outputs of the previous cycle, drive new
  // requests, check the combinational grant, then record expectations.
  task automatic step(input string name, input logic [1:0] r, input logic [1:0] w,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] eg);
    logic        g;
    logic [7:0]  ga;
    logic [31:0] gd;
    @(negedge clk);
    if (mon_en) begin
      n_vec++;
      if ({m1_read, m1_write, m1_addr, m1_wdata} !== {exp_mread, exp_mwrite, exp_maddr, exp_mwdata}) begin
        n_err++;
        $display("FAIL %s_issue_lat1 cyc=%0d got rd=%b wr=%b a=%h d=%h want rd=%b wr=%b a=%h d=%h", name, cyc,
                 m1_read, m1_write, m1_addr, m1_wdata, exp_mread, exp_mwrite, exp_maddr, exp_mwdata);
      end
      n_vec++;
      if ({m2_read, m2_write, m2_addr, m2_wdata} !== {exp_mread, exp_mwrite, exp_maddr, exp_mwdata}) begin
        n_err++;
        $display("FAIL %s_issue_lat2 cyc=%0d got rd=%b wr=%b a=%h d=%h want rd=%b wr=%b a=%h d=%h", name, cyc,
                 m2_read, m2_write, m2_addr, m2_wdata, exp_mread, exp_mwrite, exp_maddr, exp_mwdata);
      end
    end
    req = r; we = w; addr = {a1, a0}; wdata = {d1, d0};
    #1;
    n_vec++;
    if (bus1.grant !== eg || bus2.grant !== eg) begin
      n_err++;
      $display("FAIL %s_grant cyc=%0d got %b/%b want %b", name, cyc, bus1.grant, bus2.grant, eg);
    end
    $display("cyc=%0d %s req=%b we=%b grant=%b/%b", cyc, name, r, w, bus1.grant, bus2.grant);
    if (eg != 2'b00) begin
      g  = eg[1];
      ga = g ? a1 : a0;
      gd = g ? d1 : d0;
      exp_mread  = ~w[g];
      exp_mwrite = w[g];
      exp_maddr  = ga;
      exp_mwdata = gd;
      if (w[g]) ref_mem[ga] = gd;
      else begin
        q1.push_back('{eg, ref_mem[ga], cyc + 3});
        q2.push_back('{eg, ref_mem[ga], cyc + 4});
      end
    end else begin
      exp_mread  = 1'b0;
      exp_mwrite = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    if (mon_en) begin
      n_vec++;
      if ({m1_read, m2_read, m1_write, m2_write} !== {exp_mread, exp_mread, exp_mwrite, exp_mwrite}) begin
        n_err++;
        $display("FAIL pre_reset_issue cyc=%0d got rd=%b%b wr=%b%b want rd=%b wr=%b",
                 cyc, m1_read, m2_read, m1_write, m2_write, exp_mread, exp_mwrite);
      end
    end
    reset = 1'b1; req = '0; we = '0;
    q1.delete(); q2.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({bus1.grant, bus2.grant, m1_read, m1_write, m2_read, m2_write, m1_addr, m2_addr,
           m1_wdata, m2_wdata, bus1.rvalid, bus2.rvalid, bus1.rdata, bus2.rdata} !== '0) begin
        n_err++;
        $display("FAIL reset_state cyc=%0d g=%b/%b rd=%b/%b wr=%b/%b a=%h/%h rv=%b/%b rdata=%h/%h",
                 cyc, bus1.grant, bus2.grant, m1_read, m2_read, m1_write, m2_write, m1_addr, m2_addr,
                 bus1.rvalid, bus2.rvalid, bus1.rdata, bus2.rdata);
      end
      $display("cyc=%0d reset held", cyc);
    end
    reset = 1'b0;
    exp_mread = 1'b0; exp_mwrite = 1'b0; exp_maddr = '0; exp_mwdata = '0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(2);
    idle(3);
  endtask

  task automatic test_write_read;
    step("wr0", 2'b01, 2'b01, 8'h12, 8'h00, 32'hDEADBEEF, 32'h0, 2'b01);
    step("rd0", 2'b01, 2'b00, 8'h12, 8'h00, 32'h11111111, 32'h0, 2'b01);
    idle(6);
  endtask

  task automatic test_round_robin;
    do_reset(1);
    for (int i = 0; i < 8; i++)
      step("rr", 2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0, (i % 2 == 0) ? 2'b01 : 2'b10);
    idle(6);
  endtask

  task automatic test_back_to_back;
    step("b2b_w", 2'b10, 2'b10, 8'h00, 8'h11, 32'h0, 32'hC0FFEE11, 2'b10);
    for (int i = 0; i < 4; i++)
      step("b2b", 2'b10, 2'b00, 8'h00, 8'(8'h10 + i), 32'h0, 32'h0, 2'b10);
    idle(6);
  endtask

  task automatic test_pointer_hold;
    step("ph1", 2'b10, 2'b00, 8'h30, 8'h31, 32'h0, 32'h0, 2'b10);
    idle(3);
    step("ph_both", 2'b11, 2'b01, 8'h32, 8'h33, 32'h12345678, 32'h9ABCDEF0, 2'b01);
    step("ph_both", 2'b11, 2'b01, 8'h32, 8'h33, 32'h12345678, 32'h9ABCDEF0, 2'b10);
    step("ph_rd", 2'b01, 2'b00, 8'h32, 8'h33, 32'h0, 32'h0, 2'b01);
    idle(6);
  endtask

  task automatic test_reset_midflight;
    step("mf_rd", 2'b01, 2'b00, 8'h20, 8'h00, 32'h0, 32'h0, 2'b01);
    do_reset(1);
    idle(6);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_pointer_hold();
    test_reset_midflight();
    n_vec++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_err++;
      $display("FAIL pending_returns got %0d/%0d want 0/0", q1.size(), q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
